csa_accum_seq: RTL and testbench

- Sequencer that time-shares one BITS-wide carry-save adder stage to sum a variable-length stream of operands for the vector unit (dot-product and reduction partial sums).
- Keeps the running total in redundant sum/carry registers: one CSA step per accepted operand, no carry propagation.
- After the group's last operand, does a single carry-propagate add and returns the result over a valid/ready handshake.

---
 rtl/csa_accum_seq.sv | 135 +++++++++++++
 tb/tb_csa_accum_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_seq.sv
`timescale 1ns / 1ps
// Carry-save accumulation sequencer: one CSA step per operand, one carry-propagate add per group.
// Optional guard-bit overflow detection is enabled by defining CSA_ACCUM_OVF_EN.
module csa_accum_seq #(
  parameter int unsigned BITS    = 48,
  parameter int unsigned MAX_OPS = 64,
  localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            op_valid_i,
  output logic            op_ready_o,
  input  logic [BITS-1:0] op_data_i,
  input  logic            op_last_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [BITS-1:0] res_data_o,
  output logic [CW-1:0]   res_count_o,
  output logic            res_ovf_o
);

`ifdef CSA_ACCUM_OVF_EN
  // Guard bits make sum_q + carry_q exact for up to MAX_OPS operands.
  localparam int unsigned WW = BITS + CW;
`else
  localparam int unsigned WW = BITS;
`endif

  typedef enum logic [1:0] {StIdle, StAccum, StResolve, StOut} state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     sum_q, sum_d;
  logic [WW-1:0]     carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   res_data_q, res_data_d;
  logic [CW-1:0]     res_count_q, res_count_d;
  logic              res_valid_q, res_valid_d;
  logic              res_ovf_q, res_ovf_d;

  logic [WW-1:0]     x_w;
  logic [WW-1:0]     csa_s;
  logic [WW-1:0]     csa_c;
  logic [WW-1:0]     wide_sum;
  logic [CW-1:0]     cnt_inc;
  logic              accept;

  assign x_w      = WW'(op_data_i);
  assign csa_s    = sum_q ^ carry_q ^ x_w;
  // Majority shifted left by one; the top majority bit falls off the register.
  assign csa_c    = {(sum_q[WW-2:0] & carry_q[WW-2:0]) | (carry_q[WW-2:0] & x_w[WW-2:0]) |
                     (x_w[WW-2:0] & sum_q[WW-2:0]), 1'b0};
  assign wide_sum = sum_q + carry_q;
  assign cnt_inc  = cnt_q + 1'b1;

  assign op_ready_o = (state_q == StIdle) || (state_q == StAccum);
  assign accept     = op_valid_i && op_ready_o;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    res_valid_d = res_valid_q;
    res_ovf_d   = res_ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sum_d   = x_w;
          carry_d = '0;
          cnt_d   = CW'(1);
          state_d = (op_last_i || (MAX_OPS == 1)) ? StResolve : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          sum_d   = csa_s;
          carry_d = csa_c;
          cnt_d   = cnt_inc;
          if (op_last_i || (cnt_inc == CW'(MAX_OPS))) begin
            state_d = StResolve;
          end
        end
      end
      StResolve: begin
        res_data_d  = wide_sum[BITS-1:0];
        res_count_d = cnt_q;
        res_valid_d = 1'b1;
`ifdef CSA_ACCUM_OVF_EN
        res_ovf_d   = |wide_sum[WW-1:BITS];
`else
        res_ovf_d   = 1'b0;
`endif
        state_d     = StOut;
      end
      StOut: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      res_valid_q <= res_valid_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign res_data_o  = res_data_q;
  assign res_count_o = res_count_q;
  assign res_valid_o = res_valid_q;
  assign res_ovf_o   = res_ovf_q;

endmodule

// File: tb/tb_csa_accum_seq.sv
`timescale 1ns / 1ps
// Scoreboard bench for csa_accum_seq at BITS=8, MAX_OPS=4: directed scenarios then random streams.
module tb_csa_accum_seq;
  localparam int unsigned BITS    = 8;
  localparam int unsigned MAX_OPS = 4;
  localparam int unsigned CW      = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            op_valid = 1'b0;
  logic            op_ready_o;
  logic [BITS-1:0] op_data = '0;
  logic            op_last = 1'b0;
  logic            res_valid_o;
  logic            res_ready = 1'b0;
  logic [BITS-1:0] res_data_o;
  logic [CW-1:0]   res_count_o;
  logic            res_ovf_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [BITS-1:0] data;
    logic [CW-1:0]   cnt;
    logic            ovf;
  } exp_t;
  exp_t sb[$];

  csa_accum_seq #(.BITS(BITS), .MAX_OPS(MAX_OPS)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .op_valid_i (op_valid),
    .op_ready_o (op_ready_o),
    .op_data_i  (op_data),
    .op_last_i  (op_last),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready),
    .res_data_o (res_data_o),
    .res_count_o(res_count_o),
    .res_ovf_o  (res_ovf_o)
  );

  always #5 clk = ~clk;

  function automatic logic ovf_of(input int unsigned exact);
`ifdef CSA_ACCUM_OVF_EN
    return exact > 255;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk(input int unsigned exact, input int unsigned n);
    exp_t e;
    e.data = exact[BITS-1:0];
    e.cnt  = CW'(n);
    e.ovf  = ovf_of(exact);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [BITS-1:0] d, input logic l);
    int n;
    n = 0;
    op_valid = 1'b1;
    op_data  = d;
    op_last  = l;
    while (!op_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: op_ready_o=%b after %0d cycles, required 1", op_ready_o, n);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  task automatic wait_result(output logic ok);
    int n;
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = res_valid_o;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL result_timeout: res_valid_o=%b after %0d cycles, required 1", res_valid_o, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (op_ready_o !== 1'b1) begin
      failures++; $display("FAIL reset_op_ready: got %b, required 1", op_ready_o);
    end
    checks++;
    if ({res_valid_o, res_ovf_o} !== 2'b00) begin
      failures++; $display("FAIL reset_valid_ovf: got %b%b, required 00", res_valid_o, res_ovf_o);
    end
    checks++;
    if ({res_data_o, res_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_data_count: got %h/%0d, required 00/0", res_data_o, res_count_o);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    res_ready = 1'b1;
    sb.push_back(mk(32'h0F, 3));
    send_beat(8'h03, 1'b0);
    send_beat(8'h05, 1'b0);
    send_beat(8'h07, 1'b1);
    checks++;
    if (res_valid_o !== 1'b0) begin
      failures++; $display("FAIL latency_early: res_valid_o=%b during resolve, required 0", res_valid_o);
    end
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b1) begin
      failures++; $display("FAIL latency_valid: res_valid_o=%b, required 1", res_valid_o);
    end
    e = sb.pop_front();
    checks++;
    if ({res_data_o, res_count_o, res_ovf_o} !== {e.data, e.cnt, e.ovf}) begin
      failures++;
      $display("FAIL basic_result: got %h/%0d/%b, required %h/%0d/%b", res_data_o, res_count_o,
               res_ovf_o, e.data, e.cnt, e.ovf);
    end
    checks++;
    if (op_ready_o !== 1'b0) begin
      failures++; $display("FAIL basic_out_ready: op_ready_o=%b, required 0", op_ready_o);
    end
    @(negedge clk);
    checks++;
    if ({res_valid_o, op_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL basic_handoff: valid/ready=%b%b, required 01", res_valid_o, op_ready_o);
    end
  endtask

  task automatic test_ovf();
    exp_t e;
    logic ok;
    res_ready = 1'b1;
    sb.push_back(mk(32'h100, 2));
    send_beat(8'hFF, 1'b0);
    send_beat(8'h01, 1'b1);
    wait_result(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++;
      if ({res_data_o, res_count_o, res_ovf_o} !== {e.data, e.cnt, e.ovf}) begin
        failures++;
        $display("FAIL ovf_result: got %h/%0d/%b, required %h/%0d/%b", res_data_o, res_count_o,
                 res_ovf_o, e.data, e.cnt, e.ovf);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    exp_t e;
    logic ok;
    res_ready = 1'b0;
    sb.push_back(mk(32'h2A, 1));
    send_beat(8'h2A, 1'b1);
    wait_result(ok);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({res_valid_o, op_ready_o, res_data_o, res_count_o} !== {2'b10, e.data, e.cnt}) begin
        failures++;
        $display("FAIL hold_cycle%0d: valid/ready=%b%b data=%h cnt=%0d, required 10 %h %0d", i,
                 res_valid_o, op_ready_o, res_data_o, res_count_o, e.data, e.cnt);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid_o !== 1'b0) begin
      failures++; $display("FAIL hold_release: res_valid_o=%b, required 0", res_valid_o);
    end
  endtask

  task automatic test_forced_close();
    exp_t e;
    logic ok;
    res_ready = 1'b1;
    sb.push_back(mk(4, 4));
    for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
    wait_result(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++;
      if ({res_data_o, res_count_o} !== {e.data, e.cnt}) begin
        failures++;
        $display("FAIL forced_result: got %h/%0d, required %h/%0d", res_data_o, res_count_o,
                 e.data, e.cnt);
      end
    end
    @(negedge clk);
    send_beat(8'h01, 1'b0);
    send_beat(8'h01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({res_valid_o, op_ready_o} !== 2'b01) begin
        failures++;
        $display("FAIL forced_open_group: valid/ready=%b%b, required 01", res_valid_o, op_ready_o);
      end
      @(negedge clk);
    end
    sb.push_back(mk(3, 3));
    send_beat(8'h01, 1'b1);
    wait_result(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++;
      if ({res_data_o, res_count_o} !== {e.data, e.cnt}) begin
        failures++;
        $display("FAIL forced_second: got %h/%0d, required %h/%0d", res_data_o, res_count_o,
                 e.data, e.cnt);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    exp_t e;
    logic ok;
    res_ready = 1'b1;
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({res_valid_o, op_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_state: valid/ready=%b%b, required 01", res_valid_o, op_ready_o);
    end
    sb.push_back(mk(5, 1));
    send_beat(8'h05, 1'b1);
    wait_result(ok);
    e = sb.pop_front();
    if (ok) begin
      checks++;
      if ({res_data_o, res_count_o} !== {e.data, e.cnt}) begin
        failures++;
        $display("FAIL midreset_result: got %h/%0d, required %h/%0d", res_data_o, res_count_o,
                 e.data, e.cnt);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    localparam int NGRP = 60;
    int got;
    got = 0;
    fork
      begin
        for (int g = 0; g < NGRP; g++) begin
          int unsigned len, exact;
          len = $urandom_range(1, MAX_OPS);
          exact = 0;
          for (int i = 0; i < int'(len); i++) begin
            logic [BITS-1:0] d;
            logic l;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = BITS'($urandom);
            exact += d;
            l = 1'b0;
            if (i == int'(len) - 1) begin
              sb.push_back(mk(exact, len));
              l = (len < MAX_OPS) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            send_beat(d, l);
          end
        end
      end
      begin
        int n;
        n = 0;
        while (got < NGRP && n < 20000) begin
          @(negedge clk);
          n++;
          res_ready = 1'($urandom_range(0, 1));
          if (res_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL rand_extra: result %h with empty scoreboard, required none", res_data_o);
            end else if ({res_data_o, res_count_o, res_ovf_o, op_ready_o} !==
                         {sb[0].data, sb[0].cnt, sb[0].ovf, 1'b0}) begin
              failures++;
              $display("FAIL rand_result%0d: got %h/%0d/%b ready=%b, required %h/%0d/%b ready=0",
                       got, res_data_o, res_count_o, res_ovf_o, op_ready_o, sb[0].data,
                       sb[0].cnt, sb[0].ovf);
            end
            if (res_ready) begin
              if (sb.size() != 0) void'(sb.pop_front());
              got++;
            end
          end
        end
        checks++;
        if (got < NGRP) begin
          failures++; $display("FAIL rand_timeout: got %0d results, required %0d", got, NGRP);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL rand_leftover: %0d expected results unseen, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf();
    test_hold();
    test_forced_close();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
